estacao_reserva_add: RTL and testbench

ESTACAO_RESERVA_ADD -- requirements
Module: estacao_reserva_add

---
 rtl/estacao_reserva_add_pkg.sv | 35 +++
 rtl/unidade_soma_sub.sv | 22 ++
 rtl/estacao_reserva_add.sv | 161 ++++++++++++++++
 tb/tb_estacao_reserva_add.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/estacao_reserva_add_pkg.sv
// ---------------------------------------------------------------------------
// estacao_reserva_add_pkg
// Shared definitions for the ADD reservation station: producer tags seen on
// the common data bus, the "empty value" sentinel, opcode codes and the
// station state encoding. No ports; imported by the station and its datapath.
// ---------------------------------------------------------------------------
package estacao_reserva_add_pkg;

    // Producer tags; FREE means the operand value is already present
    localparam logic [2:0] TAG_FREE = 3'd0;
    localparam logic [2:0] TAG_ADD1 = 3'd1;
    localparam logic [2:0] TAG_ADD2 = 3'd2;

    // Value shown on idle result outputs and held in unused operand slots
    localparam logic [15:0] SENTINEL = 16'hFFF0;

    // Only SUB is decoded; every other opcode performs an add
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_OPS  = 2'd1,
        EXEC      = 2'd2,
        BROADCAST = 2'd3
    } state_t;

    // True when a pending tag is satisfied by the current CDB broadcast
    function automatic logic tagHits(input logic [2:0] q,
                                     input logic       cdbValid,
                                     input logic [2:0] cdbTag);
        return (q != TAG_FREE) && cdbValid && (cdbTag == q);
    endfunction

endpackage

// File: rtl/unidade_soma_sub.sv
// ---------------------------------------------------------------------------
// unidade_soma_sub
// Purely combinational 16-bit add/subtract unit. Carry and borrow are
// dropped, so results wrap modulo 2^16.
//   a_i   [15:0] in  : first operand (Vj)
//   b_i   [15:0] in  : second operand (Vk)
//   sub_i        in  : 1 = a_i - b_i, 0 = a_i + b_i
//   y_o   [15:0] out : result
// ---------------------------------------------------------------------------
module unidade_soma_sub (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        sub_i,
    output logic [15:0] y_o
);

    always_comb begin
        if (sub_i) y_o = a_i - b_i;
        else       y_o = a_i + b_i;
    end

endmodule

// File: rtl/estacao_reserva_add.sv
// ---------------------------------------------------------------------------
// estacao_reserva_add
// Single-entry Tomasulo reservation station for add/sub. Captures an
// instruction in IDLE, snoops the CDB for missing operands, executes for
// LATENCY cycles, then requests the CDB and holds the result until granted.
//   Clock, Reset (async, active-low)
//   Enable_VQ, Opcode, Vj, Vk, Qj, Qk, R_target : dispatch interface
//   CDB_Valid, CDB_Tag, CDB_Data                : CDB snoop
//   CDB_Grant                                   : arbiter grant
//   Busy, CDB_Req, Result_Tag/Data/Reg          : status and broadcast
// ---------------------------------------------------------------------------
module estacao_reserva_add
    import estacao_reserva_add_pkg::*;
#(
    parameter logic [2:0] STATION_ID = 3'd1,
    parameter int         LATENCY    = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Enable_VQ,
    input  logic [2:0]  Opcode,
    input  logic [15:0] Vj,
    input  logic [15:0] Vk,
    input  logic [2:0]  Qj,
    input  logic [2:0]  Qk,
    input  logic [2:0]  R_target,
    input  logic        CDB_Valid,
    input  logic [2:0]  CDB_Tag,
    input  logic [15:0] CDB_Data,
    input  logic        CDB_Grant,
    output logic        Busy,
    output logic        CDB_Req,
    output logic [2:0]  Result_Tag,
    output logic [15:0] Result_Data,
    output logic [2:0]  Result_Reg
);

    // Counter reload: EXEC spans LATENCY edges, the last one at count 0
    localparam logic [2:0] LAT_M1 = 3'(LATENCY - 1);

    state_t      state_q,   state_d;
    logic [2:0]  opcode_q,  opcode_d;
    logic [2:0]  rtarget_q, rtarget_d;
    logic [15:0] vj_q,      vj_d;
    logic [15:0] vk_q,      vk_d;
    logic [2:0]  qj_q,      qj_d;
    logic [2:0]  qk_q,      qk_d;
    logic [2:0]  count_q,   count_d;
    logic [15:0] result_q,  result_d;
    logic [15:0] aluOut;

    unidade_soma_sub u_alu (
        .a_i   (vj_q),
        .b_i   (vk_q),
        .sub_i (opcode_q == OP_SUB),
        .y_o   (aluOut)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            opcode_q  <= OP_ADD;
            rtarget_q <= 3'd0;
            vj_q      <= SENTINEL;
            vk_q      <= SENTINEL;
            qj_q      <= TAG_FREE;
            qk_q      <= TAG_FREE;
            count_q   <= 3'd0;
            result_q  <= SENTINEL;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            rtarget_q <= rtarget_d;
            vj_q      <= vj_d;
            vk_q      <= vk_d;
            qj_q      <= qj_d;
            qk_q      <= qk_d;
            count_q   <= count_d;
            result_q  <= result_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        rtarget_d = rtarget_q;
        vj_d      = vj_q;
        vk_d      = vk_q;
        qj_d      = qj_q;
        qk_d      = qk_q;
        count_d   = count_q;
        result_d  = result_q;

        unique case (state_q)
            IDLE: begin
                if (Enable_VQ) begin
                    opcode_d  = Opcode;
                    rtarget_d = R_target;
                    // An operand broadcast on the capture edge is taken directly
                    if (tagHits(Qj, CDB_Valid, CDB_Tag)) begin
                        vj_d = CDB_Data;
                        qj_d = TAG_FREE;
                    end else begin
                        vj_d = Vj;
                        qj_d = Qj;
                    end
                    if (tagHits(Qk, CDB_Valid, CDB_Tag)) begin
                        vk_d = CDB_Data;
                        qk_d = TAG_FREE;
                    end else begin
                        vk_d = Vk;
                        qk_d = Qk;
                    end
                    if (qj_d == TAG_FREE && qk_d == TAG_FREE) begin
                        state_d = EXEC;
                        count_d = LAT_M1;
                    end else begin
                        state_d = WAIT_OPS;
                    end
                end
            end
            WAIT_OPS: begin
                if (tagHits(qj_q, CDB_Valid, CDB_Tag)) begin
                    vj_d = CDB_Data;
                    qj_d = TAG_FREE;
                end
                if (tagHits(qk_q, CDB_Valid, CDB_Tag)) begin
                    vk_d = CDB_Data;
                    qk_d = TAG_FREE;
                end
                // Leave on the same edge the last tag clears
                if (qj_d == TAG_FREE && qk_d == TAG_FREE) begin
                    state_d = EXEC;
                    count_d = LAT_M1;
                end
            end
            EXEC: begin
                if (count_q == 3'd0) begin
                    result_d = aluOut;
                    state_d  = BROADCAST;
                end else begin
                    count_d = count_q - 3'd1;
                end
            end
            BROADCAST: begin
                if (CDB_Grant) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // All outputs decode registered state only
    always_comb begin
        Busy        = (state_q != IDLE);
        CDB_Req     = (state_q == BROADCAST);
        Result_Tag  = CDB_Req ? STATION_ID : TAG_FREE;
        Result_Data = CDB_Req ? result_q   : SENTINEL;
        Result_Reg  = CDB_Req ? rtarget_q  : 3'd0;
    end

endmodule

// File: tb/tb_estacao_reserva_add.sv
// ---------------------------------------------------------------------------
// tb_estacao_reserva_add
// Directed self-checking bench for estacao_reserva_add (STATION_ID=1,
// LATENCY=2). Expected broadcasts are queued at dispatch and popped when
// CDB_Req rises.
// ---------------------------------------------------------------------------
module tb_estacao_reserva_add;

    logic        Clock;
    logic        Reset;
    logic        Enable_VQ;
    logic [2:0]  Opcode;
    logic [15:0] Vj, Vk;
    logic [2:0]  Qj, Qk;
    logic [2:0]  R_target;
    logic        CDB_Valid;
    logic [2:0]  CDB_Tag;
    logic [15:0] CDB_Data;
    logic        CDB_Grant;
    logic        Busy;
    logic        CDB_Req;
    logic [2:0]  Result_Tag;
    logic [15:0] Result_Data;
    logic [2:0]  Result_Reg;

    typedef struct packed {
        logic [2:0]  tag;
        logic [15:0] data;
        logic [2:0]  rg;
    } expect_t;

    expect_t sb[$];
    int testsRun    = 0;
    int testsFailed = 0;

    estacao_reserva_add #(.STATION_ID(3'd1), .LATENCY(2)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Enable_VQ   (Enable_VQ),
        .Opcode      (Opcode),
        .Vj          (Vj),
        .Vk          (Vk),
        .Qj          (Qj),
        .Qk          (Qk),
        .R_target    (R_target),
        .CDB_Valid   (CDB_Valid),
        .CDB_Tag     (CDB_Tag),
        .CDB_Data    (CDB_Data),
        .CDB_Grant   (CDB_Grant),
        .Busy        (Busy),
        .CDB_Req     (CDB_Req),
        .Result_Tag  (Result_Tag),
        .Result_Data (Result_Data),
        .Result_Reg  (Result_Reg)
    );

    // Free-running 10 ns clock
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Hard stop in case the sequence itself stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Drive one dispatch for a single edge, then drop the strobe
    task automatic applyStimulus(input logic [2:0] op, input logic [15:0] vj, input logic [2:0] qj,
                                 input logic [15:0] vk, input logic [2:0] qk, input logic [2:0] rt);
        Opcode    = op;
        Vj        = vj;
        Qj        = qj;
        Vk        = vk;
        Qk        = qk;
        R_target  = rt;
        Enable_VQ = 1'b1;
        tick();
        Enable_VQ = 1'b0;
    endtask

    task automatic pushExpect(input logic [15:0] data, input logic [2:0] rg);
        expect_t e;
        e.tag  = 3'd1;
        e.data = data;
        e.rg   = rg;
        sb.push_back(e);
    endtask

    // Wait (bounded) for CDB_Req, check the cycle count, compare with scoreboard
    task automatic waitBroadcast(input string name, input int expCycles);
        int n = 0;
        expect_t e;
        while (CDB_Req !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        checkOutput({name, "_req"}, {31'd0, CDB_Req}, 32'd1);
        checkOutput({name, "_latency"}, n, expCycles);
        if (sb.size() == 0) begin
            checkOutput({name, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            checkOutput({name, "_tag"},  {29'd0, Result_Tag},  {29'd0, e.tag});
            checkOutput({name, "_data"}, {16'd0, Result_Data}, {16'd0, e.data});
            checkOutput({name, "_reg"},  {29'd0, Result_Reg},  {29'd0, e.rg});
        end
    endtask

    task automatic grantAndRelease(input string name);
        CDB_Grant = 1'b1;
        tick();
        CDB_Grant = 1'b0;
        checkOutput({name, "_busy_after_grant"}, {31'd0, Busy}, 32'd0);
        checkOutput({name, "_req_after_grant"}, {31'd0, CDB_Req}, 32'd0);
        checkOutput({name, "_data_after_grant"}, {16'd0, Result_Data}, 32'h0000FFF0);
    endtask

    task automatic checkIdleOutputs(input string name);
        checkOutput({name, "_busy"}, {31'd0, Busy}, 32'd0);
        checkOutput({name, "_req"},  {31'd0, CDB_Req}, 32'd0);
        checkOutput({name, "_tag"},  {29'd0, Result_Tag}, 32'd0);
        checkOutput({name, "_data"}, {16'd0, Result_Data}, 32'h0000FFF0);
        checkOutput({name, "_reg"},  {29'd0, Result_Reg}, 32'd0);
    endtask

    initial begin
        Reset = 1'b0; Enable_VQ = 1'b0; Opcode = 3'd0;
        Vj = 16'd0; Vk = 16'd0; Qj = 3'd0; Qk = 3'd0; R_target = 3'd0;
        CDB_Valid = 1'b0; CDB_Tag = 3'd0; CDB_Data = 16'd0; CDB_Grant = 1'b0;

        // Reset values
        #12;
        checkIdleOutputs("reset");
        Reset = 1'b1;
        tick();

        // Ready operands: 5 + 3 -> reg 4
        pushExpect(16'd8, 3'd4);
        applyStimulus(3'b001, 16'd5, 3'd0, 16'd3, 3'd0, 3'd4);
        checkOutput("ready_busy", {31'd0, Busy}, 32'd1);
        waitBroadcast("ready", 2);
        grantAndRelease("ready");

        // Wait on CDB: Vj from ADD2 = 25, 25 - 10 = 15
        pushExpect(16'd15, 3'd3);
        applyStimulus(3'b010, 16'd99, 3'd2, 16'd10, 3'd0, 3'd3);
        CDB_Valid = 1'b1; CDB_Tag = 3'd1; CDB_Data = 16'd1000;
        tick();
        CDB_Valid = 1'b0;
        tick();
        checkOutput("wait_busy", {31'd0, Busy}, 32'd1);
        checkOutput("wait_noreq", {31'd0, CDB_Req}, 32'd0);
        CDB_Valid = 1'b1; CDB_Tag = 3'd2; CDB_Data = 16'd25;
        tick();
        // Further ADD2 traffic during EXEC must not touch the operands
        CDB_Data = 16'd500;
        waitBroadcast("wait", 2);
        CDB_Valid = 1'b0;
        grantAndRelease("wait");

        // Capture bypass of both operands: 7 + 7
        pushExpect(16'd14, 3'd6);
        CDB_Valid = 1'b1; CDB_Tag = 3'd2; CDB_Data = 16'd7;
        applyStimulus(3'b001, 16'd0, 3'd2, 16'd0, 3'd2, 3'd6);
        CDB_Valid = 1'b0;
        waitBroadcast("bypass", 2);
        grantAndRelease("bypass");

        // Both tags resolve on one WAIT_OPS edge: 9 + 9
        pushExpect(16'd18, 3'd5);
        applyStimulus(3'b001, 16'd0, 3'd2, 16'd0, 3'd2, 3'd5);
        checkOutput("double_waiting", {31'd0, CDB_Req}, 32'd0);
        CDB_Valid = 1'b1; CDB_Tag = 3'd2; CDB_Data = 16'd9;
        tick();
        CDB_Valid = 1'b0;
        waitBroadcast("double", 2);
        grantAndRelease("double");

        // Grant stall with an ignored second dispatch: 100 - 1
        pushExpect(16'd99, 3'd7);
        applyStimulus(3'b010, 16'd100, 3'd0, 16'd1, 3'd0, 3'd7);
        waitBroadcast("stall", 2);
        for (int i = 0; i < 3; i++) begin
            Enable_VQ = (i == 1); Vj = 16'd1; Vk = 16'd1; Opcode = 3'b001; R_target = 3'd2;
            tick();
            checkOutput("stall_req",  {31'd0, CDB_Req}, 32'd1);
            checkOutput("stall_data", {16'd0, Result_Data}, 32'd99);
            checkOutput("stall_reg",  {29'd0, Result_Reg}, 32'd7);
        end
        Enable_VQ = 1'b0;
        grantAndRelease("stall");
        tick();
        checkOutput("stall_second_ignored", {31'd0, Busy}, 32'd0);

        // Wraparound add (opcode 111 is ADD) and subtract borrow
        pushExpect(16'h0000, 3'd2);
        applyStimulus(3'b111, 16'hFFFF, 3'd0, 16'd1, 3'd0, 3'd2);
        waitBroadcast("wrap_add", 2);
        grantAndRelease("wrap_add");
        pushExpect(16'hFFFF, 3'd1);
        applyStimulus(3'b010, 16'd0, 3'd0, 16'd1, 3'd0, 3'd1);
        waitBroadcast("wrap_sub", 2);
        grantAndRelease("wrap_sub");

        // Reset mid-EXEC: nothing may be broadcast
        applyStimulus(3'b001, 16'd2, 3'd0, 16'd2, 3'd0, 3'd3);
        checkOutput("midexec_busy", {31'd0, Busy}, 32'd1);
        #3 Reset = 1'b0;
        #1 checkIdleOutputs("midexec_reset");
        Reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("midexec_no_broadcast", {31'd0, CDB_Req}, 32'd0);
        end

        // Reset while broadcasting
        pushExpect(16'd30, 3'd4);
        applyStimulus(3'b001, 16'd20, 3'd0, 16'd10, 3'd0, 3'd4);
        waitBroadcast("bcast", 2);
        #2 Reset = 1'b0;
        #1 checkIdleOutputs("bcast_reset");
        Reset = 1'b1;
        tick();
        checkOutput("bcast_stays_idle", {31'd0, Busy}, 32'd0);

        checkOutput("scoreboard_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
